mem_load_writer: RTL and testbench
==================================

Name: mem_load_writer

Overview:
- Writable counterpart to the team's 16x8 lookup ROM: a 16-entry x 8-bit register-file memory, filled by a burst-write engine.
- The engine accepts a byte stream over a valid/ready handshake and auto-increments the write address with wrap-around.
- It reports progress, a mod-256 checksum, and a completion pulse.
- A combinational read port (address in, data out) lets it drop in wherever the fixed ROM is read today.

Parameters:
- ADDR_W, 4, address width; depth = 2**ADDR_W = 16.
- DATA_W, 8, byte width of the memory and stream.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a burst; honoured only in IDLE.
- start_addr  input  ADDR_W  first write address, sampled with start.
- length  input  ADDR_W+1  burst length in bytes, sampled with start; 0 = no-op; values >16 clamp to 16.
- abort  input  1  cancels an active burst.
- wr_valid  input  1  wr_data is valid.
- wr_data  input  DATA_W  byte to write.
- wr_ready  output  1  engine accepts a byte this cycle.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse when a burst (or no-op) completes.
- wr_count  output  ADDR_W+1  bytes written in the current/last burst.
- checksum  output  DATA_W  mod-256 sum of bytes written in the current/last burst.
- address  input  ADDR_W  read address.
- data  output  DATA_W  memory contents at address, combinational.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - All 16 memory words are cleared to 0x00.
  - wr_ready=0, busy=0, done=0, wr_count=0, checksum=0; FSM goes to IDLE.
  - data therefore reads 0x00 at every address.
- States: IDLE, LOAD, DONE.
- IDLE, start=1 and length!=0:
  - ptr<=start_addr; remaining<=min(length,16); wr_count<=0; checksum<=0; go to LOAD.
- IDLE, start=1 and length==0:
  - wr_count<=0, checksum<=0, go to DONE. No memory write.
- start outside IDLE is ignored, with no effect on the burst.
- LOAD:
  - wr_ready=1 and busy=1, both decoded from state.
  - A transfer occurs on any cycle where wr_valid && wr_ready.
  - On a transfer: mem[ptr]<=wr_data; ptr<=ptr+1 mod 16; wr_count+=1; checksum<=checksum+wr_data mod 256; remaining-=1.
  - The transfer with remaining==1 moves the FSM to DONE.
  - Cycles with wr_valid=0 change nothing.
- Address wrap: ptr 15 -> 0. A 16-byte burst overwrites every word exactly once.
- abort in LOAD: the FSM returns to IDLE next cycle.
  - A byte presented with wr_valid in that same cycle is still written and counted.
  - No done pulse; wr_count and checksum hold their partial values.
  - abort in IDLE or DONE is ignored.
- DONE: lasts exactly one cycle with done=1, busy=0, wr_ready=0, then returns to IDLE.
- Latency:
  - The first byte can be accepted in the cycle after start.
  - done asserts in the cycle after the last transfer.
  - Minimum burst of N bytes: start -> done in N+1 cycles.
- Read port: data = mem[address], purely combinational.
  - If address matches the word being written, data shows the old value in the write cycle and the new value from the next cycle.
- Reset mid-burst: immediate return to the reset state; memory is cleared and the partial burst is lost.

Test Plan:
- Reset, then sweep address 0..15 -> data=0x00 everywhere; busy=0, wr_ready=0, done=0, wr_count=0, checksum=0.
- start_addr=2, length=4, stream 0x11,0x22,0x33,0x44 back-to-back -> mem[2..5] hold those bytes; done pulses 5 cycles after start; wr_count=4; checksum=0xAA; all other words 0x00.
- start_addr=14, length=4, bytes 0xF0,0xF1,0xF2,0xF3, with wr_valid dropped for 2 cycles mid-burst -> mem[14]=0xF0, mem[15]=0xF1, mem[0]=0xF2, mem[1]=0xF3; checksum=0xC6; done delayed by exactly 2 cycles.
- length=0 -> done pulses the next cycle, no memory change, wr_count=0. length=20 with 16 bytes of 0x01 -> done after the 16th byte, wr_count=16, checksum=0x10.
- start pulsed again during LOAD with different start_addr -> ignored; the original burst completes unaffected.
- Abort after 2 of 5 bytes -> no done, wr_count=2, busy=0 next cycle. Separately, assert reset_n=0 mid-burst -> memory reads all 0x00 and outputs return to reset values.

Source files
------------

// File: rtl/mem_load_writer.sv
`default_nettype none
// ============================================================================
// Module   : mem_load_writer
// Brief    : 16x8 register-file memory loaded by an auto-incrementing burst
//            write engine, with a combinational read port.
// Revision : 1.0
// ============================================================================
module mem_load_writer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              abort,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   wr_count,
    output logic [DATA_W-1:0] checksum,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data
);

    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] C_DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] C_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_remaining;
    logic [ADDR_W:0]   r_wr_count;
    logic [DATA_W-1:0] r_checksum;
    logic [ADDR_W:0]   w_len_clamped;
    logic              w_xfer;
    logic              w_accept_start;

    assign w_xfer         = (r_state == ST_LOAD) && wr_valid;
    assign w_accept_start = (r_state == ST_IDLE) && start;
    assign w_len_clamped  = (length > C_DEPTH) ? C_DEPTH : length;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // abort takes priority over completion, so an abort on the final byte
    // still writes it but suppresses the done pulse
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (length != '0) ? ST_LOAD : ST_DONE;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    w_next = ST_IDLE;
                end else if (w_xfer && (r_remaining == C_ONE)) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_xfer) begin
            r_mem[r_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr       <= '0;
            r_remaining <= '0;
            r_wr_count  <= '0;
            r_checksum  <= '0;
        end else if (w_accept_start) begin
            r_ptr       <= start_addr;
            r_remaining <= w_len_clamped;
            r_wr_count  <= '0;
            r_checksum  <= '0;
        end else if (w_xfer) begin
            r_ptr       <= r_ptr + 1'b1;
            r_remaining <= r_remaining - C_ONE;
            r_wr_count  <= r_wr_count + C_ONE;
            r_checksum  <= r_checksum + wr_data;
        end
    end

    assign wr_ready = (r_state == ST_LOAD);
    assign busy     = (r_state == ST_LOAD);
    assign done     = (r_state == ST_DONE);
    assign wr_count = r_wr_count;
    assign checksum = r_checksum;
    assign data     = r_mem[address];

endmodule
`default_nettype wire

// File: tb/tb_mem_load_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_load_writer
// Brief    : Scoreboard bench for mem_load_writer against an array model.
// Revision : 1.0
// ============================================================================
module tb_mem_load_writer;

    logic       clk        = 1'b0;
    logic       reset_n    = 1'b0;
    logic       start      = 1'b0;
    logic [3:0] start_addr = 4'd0;
    logic [4:0] length     = 5'd0;
    logic       abort      = 1'b0;
    logic       wr_valid   = 1'b0;
    logic [7:0] wr_data    = 8'd0;
    logic [3:0] address    = 4'd0;
    logic       wr_ready;
    logic       busy;
    logic       done;
    logic [4:0] wr_count;
    logic [7:0] checksum;
    logic [7:0] data;

    mem_load_writer #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .abort      (abort),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .busy       (busy),
        .done       (done),
        .wr_count   (wr_count),
        .checksum   (checksum),
        .address    (address),
        .data       (data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cnt; int sum; int cyc; } done_t;
    typedef struct { bit is_read; int data; int busy; int rdy; int cnt; int sum; } obs_t;

    done_t done_q[$];
    obs_t  obs_q[$];
    done_t m_done;
    obs_t  m_obs;
    logic  strobe = 1'b0;

    int errors = 0;
    int checks = 0;

    int mem_m[16];
    int bytes_in[16];
    int last_cnt = 0;
    int last_sum = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: done pulses and strobed observations are matched against queues
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (done_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                m_done = done_q.pop_front();
                chk("done_cycle", cyc, m_done.cyc);
                chk("done_wr_count", int'(wr_count), m_done.cnt);
                chk("done_checksum", int'(checksum), m_done.sum);
                chk("done_busy", int'(busy), 0);
                chk("done_wr_ready", int'(wr_ready), 0);
            end
        end
        if (strobe === 1'b1) begin
            if (obs_q.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                m_obs = obs_q.pop_front();
                if (m_obs.is_read) begin
                    chk($sformatf("read_data[%0d]", address), int'(data), m_obs.data);
                end else begin
                    chk("status_busy", int'(busy), m_obs.busy);
                    chk("status_wr_ready", int'(wr_ready), m_obs.rdy);
                    chk("status_done", int'(done), 0);
                    chk("status_wr_count", int'(wr_count), m_obs.cnt);
                    chk("status_checksum", int'(checksum), m_obs.sum);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input int a);
        address = 4'(a);
        obs_q.push_back('{1'b1, mem_m[a], 0, 0, 0, 0});
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
    endtask

    task automatic status_chk(input int b, input int r, input int c, input int s);
        obs_q.push_back('{1'b0, 0, b, r, c, s});
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
    endtask

    task automatic sweep();
        for (int a = 0; a < 16; a++) read_chk(a);
    endtask

    // One burst. Expected done time: one cycle for start, one per byte,
    // one per idle (wr_valid=0) cycle inside the burst.
    task automatic burst(input int sa, input int len, input int gap_at, input int gap_len,
                         input bit rnd_gap, input int abort_at, input int restart_at,
                         input int rst_at, input int probe_at);
        int n, p, gaps, s0, cnt, sum, gl, b;
        n    = (len > 16) ? 16 : len;
        p    = sa;
        gaps = 0;
        cnt  = 0;
        sum  = 0;
        start      = 1'b1;
        start_addr = 4'(sa);
        length     = 5'(len);
        s0         = cyc;
        if (n == 0) begin
            last_cnt = 0;
            last_sum = 0;
            done_q.push_back('{0, 0, s0 + 1});
        end
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            gl = (i == gap_at) ? gap_len :
                 (rnd_gap && $urandom_range(3) == 0) ? 1 + int'($urandom_range(1)) : 0;
            for (int g = 0; g < gl; g++) begin
                wr_valid = 1'b0;
                gaps++;
                tick();
            end
            if (i == rst_at) begin
                wr_valid = 1'b0;
                reset_n  = 1'b0;
                for (int k = 0; k < 16; k++) mem_m[k] = 0;
                last_cnt = 0;
                last_sum = 0;
                status_chk(0, 0, 0, 0);
                reset_n = 1'b1;
                tick();
                status_chk(0, 0, 0, 0);
                return;
            end
            b        = bytes_in[i];
            wr_valid = 1'b1;
            wr_data  = 8'(b);
            if (i == restart_at) begin
                start      = 1'b1;
                start_addr = 4'(sa + 7);
                length     = 5'd3;
            end
            if (i == abort_at) abort = 1'b1;
            cnt++;
            sum = (sum + b) % 256;
            if (i == probe_at && i != abort_at && i < n - 1) begin
                address = 4'(p);
                obs_q.push_back('{1'b1, mem_m[p], 0, 0, 0, 0});
                strobe = 1'b1;
            end
            mem_m[p] = b;
            p = (p + 1) % 16;
            if (i == abort_at) begin
                last_cnt = cnt;
                last_sum = sum;
                tick();
                abort    = 1'b0;
                start    = 1'b0;
                wr_valid = 1'b0;
                status_chk(0, 0, cnt, sum);
                return;
            end
            if (i == n - 1) begin
                last_cnt = cnt;
                last_sum = sum;
                done_q.push_back('{cnt, sum, s0 + 1 + n + gaps});
            end
            tick();
            start = 1'b0;
            if (strobe) begin
                // word just written must now read back the new byte
                wr_valid = 1'b0;
                gaps++;
                obs_q.push_back('{1'b1, b, 0, 0, 0, 0});
                tick();
                strobe = 1'b0;
            end
        end
        wr_valid = 1'b0;
        tick();
        tick();
        status_chk(0, 0, last_cnt, last_sum);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sa, len, n, ab, pr;
        for (int k = 0; k < 16; k++) mem_m[k] = 0;

        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        status_chk(0, 0, 0, 0);
        sweep();

        bytes_in[0] = 'h11; bytes_in[1] = 'h22; bytes_in[2] = 'h33; bytes_in[3] = 'h44;
        burst(2, 4, -1, 0, 1'b0, -1, -1, -1, -1);
        sweep();

        bytes_in[0] = 'hF0; bytes_in[1] = 'hF1; bytes_in[2] = 'hF2; bytes_in[3] = 'hF3;
        burst(14, 4, 2, 2, 1'b0, -1, -1, -1, -1);
        sweep();

        burst(9, 0, -1, 0, 1'b0, -1, -1, -1, -1);
        sweep();

        for (int k = 0; k < 16; k++) bytes_in[k] = 1;
        burst(5, 20, -1, 0, 1'b0, -1, -1, -1, -1);
        sweep();

        for (int k = 0; k < 16; k++) bytes_in[k] = 'h30 + k;
        burst(3, 5, -1, 0, 1'b0, -1, 2, -1, 1);
        sweep();

        for (int k = 0; k < 16; k++) bytes_in[k] = 'hA0 + k;
        burst(10, 5, -1, 0, 1'b0, 1, -1, -1, -1);
        sweep();

        for (int k = 0; k < 16; k++) bytes_in[k] = 'h5A ^ k;
        burst(6, 6, -1, 0, 1'b0, -1, -1, 3, -1);
        sweep();

        for (int t = 0; t < 25; t++) begin
            sa  = int'($urandom_range(15));
            len = int'($urandom_range(20));
            n   = (len > 16) ? 16 : len;
            for (int k = 0; k < 16; k++) bytes_in[k] = int'($urandom_range(255));
            ab  = (n > 0 && $urandom_range(7) == 0) ? int'($urandom_range(n - 1)) : -1;
            pr  = (n >= 2) ? int'($urandom_range(n - 2)) : -1;
            burst(sa, len, -1, 0, 1'b1, ab, -1, -1, pr);
            for (int r = 0; r < 4; r++) read_chk(int'($urandom_range(15)));
        end
        sweep();

        repeat (5) tick();
        chk("pending_done", done_q.size(), 0);
        chk("pending_obs", obs_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
